// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
//   Decodes a stream of PS/2 set-2 scancodes into make/break key events,
//   queues them in a small FIFO for a consumer, and keeps a bitmap of which
//   game keys (arrows, space, enter, WASD) are currently held down.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   scancode   byte from the PS/2 receiver, qualified by ready
//   ready      one-cycle strobe marking a new scancode
//   ev_valid   FIFO holds at least one event
//   ev_data    head event {ext, release, code[7:0]}, zero while empty
//   ev_ready   consumer accept; pops when ev_valid is also high
//   keys       held-key bitmap (see key_index for the bit assignment)
//   overflow   sticky, set when an event is dropped on a full FIFO
//   proto_err  one-cycle pulse on a malformed prefix sequence
//   clear      synchronous clear of overflow and keys
module ps2_key_event_ctrl #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scancode,
    input  logic       ready,
    output logic       ev_valid,
    output logic [9:0] ev_data,
    input  logic       ev_ready,
    output logic [9:0] keys,
    output logic       overflow,
    output logic       proto_err,
    input  logic       clear
);

    // FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap for free.
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tmr;
    logic            timeout;

    logic            emit;
    logic [9:0]      ev_word;
    logic            perr_set;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    logic [3:0]      kidx;
    logic [9:0]      keys_nxt;

    // Codes that carry no key information when seen outside a prefix:
    // Pause prefix, self-test/ack/resend/echo replies, error bytes.
    function automatic logic is_ignored(input logic [7:0] code);
        case (code)
            8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_ignored = 1'b1;
            default:                                         is_ignored = 1'b0;
        endcase
    endfunction

    // Bit position in keys for an {ext, code} pair; 15 means not tracked.
    // The ext flag is part of the match so keypad 8 (75) is not "up" (E0 75).
    function automatic logic [3:0] key_index(input logic ext, input logic [7:0] code);
        case ({ext, code})
            {1'b1, 8'h75}: key_index = 4'd0;
            {1'b1, 8'h72}: key_index = 4'd1;
            {1'b1, 8'h6B}: key_index = 4'd2;
            {1'b1, 8'h74}: key_index = 4'd3;
            {1'b0, 8'h29}: key_index = 4'd4;
            {1'b0, 8'h5A}: key_index = 4'd5;
            {1'b0, 8'h1D}: key_index = 4'd6;
            {1'b0, 8'h1C}: key_index = 4'd7;
            {1'b0, 8'h1B}: key_index = 4'd8;
            {1'b0, 8'h23}: key_index = 4'd9;
            default:       key_index = 4'd15;
        endcase
    endfunction

    // A prefix state gives up after TIMEOUT_CYCLES strobe-free cycles.
    assign timeout = (state != IDLE) && !ready && (tmr == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (ready || (state == IDLE) || timeout) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (ready) begin
            case (state)
                IDLE: begin
                    if (scancode == SC_EXT)      state_nxt = GOT_E0;
                    else if (scancode == SC_BRK) state_nxt = GOT_F0;
                end
                GOT_E0: begin
                    if (scancode == SC_BRK)      state_nxt = GOT_E0F0;
                    else if (scancode == SC_EXT) state_nxt = GOT_E0;
                    else                         state_nxt = IDLE;
                end
                GOT_F0, GOT_E0F0: state_nxt = IDLE;
                default:          state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        emit     = 1'b0;
        ev_word  = '0;
        perr_set = 1'b0;
        if (ready) begin
            case (state)
                IDLE: begin
                    if ((scancode != SC_EXT) && (scancode != SC_BRK) && !is_ignored(scancode)) begin
                        emit    = 1'b1;
                        ev_word = {2'b00, scancode};
                    end
                end
                GOT_E0: begin
                    if ((scancode != SC_EXT) && (scancode != SC_BRK)) begin
                        emit    = 1'b1;
                        ev_word = {2'b10, scancode};
                    end
                end
                GOT_F0: begin
                    if ((scancode == SC_EXT) || (scancode == SC_BRK)) begin
                        perr_set = 1'b1;
                    end else begin
                        emit    = 1'b1;
                        ev_word = {2'b01, scancode};
                    end
                end
                GOT_E0F0: begin
                    if ((scancode == SC_EXT) || (scancode == SC_BRK)) begin
                        perr_set = 1'b1;
                    end else begin
                        emit    = 1'b1;
                        ev_word = {2'b11, scancode};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else begin
            proto_err <= perr_set;
        end
    end

    // Event FIFO. When full, a simultaneous pop frees the slot the push
    // lands in (wr_ptr == rd_ptr), so the pair is accepted and count holds.
    assign ev_valid = (count != '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = ev_valid && ev_ready;
    assign push_ok  = emit && (!full || pop);
    assign drop     = emit && full && !pop;
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= ev_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear) begin
            overflow <= 1'b0;
        end
    end

    // Held-key bitmap tracks every decoded event, dropped or not; a make in
    // the same cycle as clear still sets its own bit.
    assign kidx = key_index(ev_word[9], ev_word[7:0]);

    always_comb begin
        keys_nxt = clear ? '0 : keys;
        if (emit) begin
            for (int i = 0; i < 10; i++) begin
                if (kidx == 4'(i)) keys_nxt[i] = ~ev_word[8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys <= '0;
        end else begin
            keys <= keys_nxt;
        end
    end

endmodule
